mbist_controller: RTL and testbench

MBIST_CONTROLLER -- requirements
Module: mbist_controller

---
 rtl/mbist_controller.sv | 163 ++++++++++++++++
 tb/tb_mbist_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_controller.sv
// March C- built-in self test controller for a single-port RAM with 2-cycle read latency.
// Muxes the RAM between functional traffic (IDLE/DONE) and the test sequencer (RUN/GAP/DRAIN).
module mbist_controller #(
   parameter int wcount  = 256,
   parameter int wlength = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [$clog2(wcount)-1:0] func_addr,
   input  logic                      func_we,
   input  logic [wlength-1:0]        func_datain,
   output logic [$clog2(wcount)-1:0] ram_addr,
   output logic                      ram_we,
   output logic [wlength-1:0]        ram_datain,
   input  logic [wlength-1:0]        ram_dataout,
   output logic                      busy,
   output logic                      done,
   output logic                      fail,
   output logic [$clog2(wcount)-1:0] fail_addr,
   output logic [2:0]                fail_element,
   output logic [7:0]                fail_count
);

   localparam int aw = $clog2(wcount);

   typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [2:0]      elem;
   logic [aw-1:0]   addr;
   logic            phase;
   logic            drain_cnt;

   logic            p1_valid, p2_valid;
   logic [wlength-1:0] p1_exp, p2_exp;
   logic [aw-1:0]   p1_addr, p2_addr;
   logic [2:0]      p1_elem, p2_elem;

   logic el_down, el_read, el_write, el_rval, el_wval;
   logic op_is_read, op_last, addr_last, mismatch;
   logic ctl_we, issue_read, passthru;

   // Element 0 is w0 only, element 5 is r0 only; the others are a read followed by a write.
   always_comb begin
      el_down    = (elem == 3'd3) || (elem == 3'd4);
      el_read    = (elem != 3'd0);
      el_write   = (elem != 3'd5);
      el_rval    = (elem == 3'd2) || (elem == 3'd4);
      el_wval    = (elem == 3'd1) || (elem == 3'd3);
      op_is_read = el_read && !phase;
      op_last    = !(el_read && el_write && !phase);
      addr_last  = el_down ? (addr == '0) : (addr == '1);
      mismatch   = p2_valid && (ram_dataout != p2_exp);
   end

   // start is a one-cycle request honoured only in IDLE/DONE; busy acknowledges it from the next cycle.
   always_comb begin
      state_nxt  = state;
      ctl_we     = 1'b0;
      issue_read = 1'b0;
      case (state)
         IDLE, DONE: if (start) state_nxt = RUN;
         RUN: begin
            issue_read = op_is_read;
            ctl_we     = !op_is_read;
            if (op_last && addr_last) state_nxt = (elem == 3'd5) ? DRAIN : GAP;
         end
         GAP:   state_nxt = RUN;
         DRAIN: if (drain_cnt) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      passthru   = (state == IDLE) || (state == DONE);
      busy       = !passthru;
      ram_addr   = passthru ? func_addr   : addr;
      ram_we     = passthru ? func_we     : ctl_we;
      ram_datain = passthru ? func_datain : {wlength{el_wval}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem         <= '0;
         addr         <= '0;
         phase        <= 1'b0;
         drain_cnt    <= 1'b0;
         p1_valid     <= 1'b0;
         p1_exp       <= '0;
         p1_addr      <= '0;
         p1_elem      <= '0;
         p2_valid     <= 1'b0;
         p2_exp       <= '0;
         p2_addr      <= '0;
         p2_elem      <= '0;
         done         <= 1'b0;
         fail         <= 1'b0;
         fail_addr    <= '0;
         fail_element <= '0;
         fail_count   <= '0;
      end else begin
         // Read context travels alongside the RAM's two-cycle latency.
         p1_valid <= issue_read;
         p1_exp   <= {wlength{el_rval}};
         p1_addr  <= addr;
         p1_elem  <= elem;
         p2_valid <= p1_valid;
         p2_exp   <= p1_exp;
         p2_addr  <= p1_addr;
         p2_elem  <= p1_elem;

         if (mismatch) begin
            fail <= 1'b1;
            if (!fail) begin
               fail_addr    <= p2_addr;
               fail_element <= p2_elem;
            end
            if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
         end

         case (state)
            IDLE, DONE: begin
               if (start) begin
                  elem         <= '0;
                  addr         <= '0;
                  phase        <= 1'b0;
                  done         <= 1'b0;
                  fail         <= 1'b0;
                  fail_addr    <= '0;
                  fail_element <= '0;
                  fail_count   <= '0;
               end
            end
            RUN: begin
               drain_cnt <= 1'b0;
               if (!op_last) begin
                  phase <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  if (addr_last) begin
                     if (elem != 3'd5) elem <= elem + 3'd1;
                     addr <= ((elem == 3'd2) || (elem == 3'd3)) ? '1 : '0;
                  end else begin
                     addr <= el_down ? addr - 1'b1 : addr + 1'b1;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
               if (drain_cnt) done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mbist_controller.sv
// Bench for mbist_controller: behavioural March C- model feeds expected op streams and results
// into queues; negedge monitors pop and compare as the DUTs present them.
module tb_mbist_controller;
   localparam int WA = 256, LA = 4, WB = 16, LB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0, miscompares = 0;

   logic       rst_a = 1'b1, start_a = 1'b0;
   logic [7:0] fa_addr = '0;
   logic       fa_we = 1'b0;
   logic [3:0] fa_din = '0;
   logic [7:0] ra_addr, faddr_a, fcnt_a;
   logic       ra_we, busy_a, done_a, fail_a;
   logic [3:0] ra_din, ra_dout;
   logic [2:0] felem_a;

   logic       rst_b = 1'b1, start_b = 1'b0;
   logic [3:0] fb_addr = '0;
   logic       fb_we = 1'b0;
   logic [7:0] fb_din = '0;
   logic [3:0] rb_addr, faddr_b;
   logic       rb_we, busy_b, done_b, fail_b;
   logic [7:0] rb_din, rb_dout, fcnt_b;
   logic [2:0] felem_b;

   mbist_controller #(.wcount(WA), .wlength(LA)) dut_a (
      .clk(clk), .rst(rst_a), .start(start_a),
      .func_addr(fa_addr), .func_we(fa_we), .func_datain(fa_din),
      .ram_addr(ra_addr), .ram_we(ra_we), .ram_datain(ra_din), .ram_dataout(ra_dout),
      .busy(busy_a), .done(done_a), .fail(fail_a),
      .fail_addr(faddr_a), .fail_element(felem_a), .fail_count(fcnt_a));

   mbist_controller #(.wcount(WB), .wlength(LB)) dut_b (
      .clk(clk), .rst(rst_b), .start(start_b),
      .func_addr(fb_addr), .func_we(fb_we), .func_datain(fb_din),
      .ram_addr(rb_addr), .ram_we(rb_we), .ram_datain(rb_din), .ram_dataout(rb_dout),
      .busy(busy_b), .done(done_b), .fail(fail_b),
      .fail_addr(faddr_b), .fail_element(felem_b), .fail_count(fcnt_b));

   // RAMs with 2-cycle read latency; stuck-at masks applied on the read path
   logic [7:0] sa1[256], sa0[256];
   logic [3:0] mem_a[WA];
   logic [3:0] rd1_a = '0, rd2_a = '0;
   logic [7:0] mem_b[WB];
   logic [7:0] rd1_b = '0, rd2_b = '0;

   always @(posedge clk) begin
      if (ra_we) mem_a[ra_addr] <= ra_din;
      rd1_a <= (mem_a[ra_addr] | sa1[ra_addr][3:0]) & ~sa0[ra_addr][3:0];
      rd2_a <= rd1_a;
      if (rb_we) mem_b[rb_addr] <= rb_din;
      rd1_b <= (mem_b[rb_addr] | sa1[8'(rb_addr)]) & ~sa0[8'(rb_addr)];
      rd2_b <= rd1_b;
   end
   assign ra_dout = rd2_a;
   assign rb_dout = rd2_b;

   logic [17:0] exp_op_q[$];   // {kind 0=idle 1=read 2=write, addr, data}
   logic [35:0] exp_a_q[$];    // {cycles, fail, fail_addr, fail_element, fail_count}
   logic [35:0] exp_b_q[$];
   int start_cyc_a = 0, start_cyc_b = 0;

   bit         rand_func = 1'b0;
   logic [7:0] pt_addr = '0;
   logic       pt_we = 1'b0;
   logic [3:0] pt_din = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         if (miscompares <= 25)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_faults(input int mode, input int wc, input int wl);
      int a, b;
      logic [7:0] mask;
      mask = 8'((1 << wl) - 1);
      for (int i = 0; i < 256; i++) begin
         sa1[i] = '0;
         sa0[i] = '0;
      end
      case (mode)
         1: if (wc == WA) sa1[5] = 8'h01; else sa0[15] = 8'h80;
         2: begin
            a = $urandom_range(wc - 1);
            b = $urandom_range(wl - 1);
            if ($urandom_range(1) == 1) sa1[a][b] = 1'b1; else sa0[a][b] = 1'b1;
         end
         3: for (int i = 0; i < wc; i++) begin
            if ($urandom_range(3) == 0) begin
               sa1[i] = 8'($urandom) & mask;
               sa0[i] = 8'($urandom) & mask & ~sa1[i];
            end
         end
         default: ;
      endcase
   endtask

   // March C- applied to a behavioural memory, one element/address/op at a time.
   task automatic model_run(input int wc, input int wl, input bit gen_ops, output logic [35:0] res);
      logic [7:0] m[256];
      logic [7:0] ones, rv, ev;
      int a, fails, f_addr, f_elem;
      bit f;
      ones = 8'((1 << wl) - 1);
      fails = 0; f = 1'b0; f_addr = 0; f_elem = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < wc; k++) begin
            a = (e == 3 || e == 4) ? wc - 1 - k : k;
            if (e != 0) begin
               rv = (m[a] | sa1[a]) & ~sa0[a] & ones;
               ev = (e == 2 || e == 4) ? ones : 8'h00;
               if (gen_ops) exp_op_q.push_back({2'd1, 8'(a), 8'h00});
               if (rv != ev) begin
                  if (!f) begin f = 1'b1; f_addr = a; f_elem = e; end
                  if (fails < 255) fails++;
               end
            end
            if (e != 5) begin
               m[a] = (e == 1 || e == 3) ? ones : 8'h00;
               if (gen_ops) exp_op_q.push_back({2'd2, 8'(a), m[a]});
            end
         end
         if (gen_ops) begin
            exp_op_q.push_back(18'h0);
            if (e == 5) exp_op_q.push_back(18'h0);
         end
      end
      res = {16'(10 * wc + 8), f, 8'(f_addr), 3'(f_elem), 8'(fails)};
   endtask

   task automatic run_a(input int mode, input int extra_at, input int abort_at);
      logic [35:0] r;
      set_faults(mode, WA, LA);
      exp_op_q.delete();
      model_run(WA, LA, 1'b1, r);
      exp_a_q.push_back(r);
      @(posedge clk); #1;
      start_a = 1'b1;
      start_cyc_a = cyc;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (extra_at > 0) begin
         while (cyc < start_cyc_a + extra_at) begin @(posedge clk); #1; end
         start_a = 1'b1;
         @(posedge clk); #1;
         start_a = 1'b0;
      end
      if (abort_at > 0) begin
         while (cyc < start_cyc_a + abort_at) begin @(posedge clk); #1; end
         rst_a = 1'b1;
         #1;
         check("abort_busy", 32'(busy_a), 32'd0);
         check("abort_done", 32'(done_a), 32'd0);
         check("abort_pass", 32'({ra_addr, ra_we, ra_din}), 32'({fa_addr, fa_we, fa_din}));
         exp_op_q.delete();
         void'(exp_a_q.pop_back());
         @(posedge clk); #1;
         rst_a = 1'b0;
      end else begin
         for (int i = 0; i < 3000 && exp_a_q.size() != 0; i++) begin @(posedge clk); #1; end
         if (exp_a_q.size() != 0) begin
            check("done_timeout_a", 32'd0, 32'd1);
            exp_a_q.delete();
            exp_op_q.delete();
         end
      end
   endtask

   task automatic run_b(input int mode);
      logic [35:0] r;
      set_faults(mode, WB, LB);
      model_run(WB, LB, 1'b0, r);
      exp_b_q.push_back(r);
      @(posedge clk); #1;
      start_b = 1'b1;
      start_cyc_b = cyc;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int i = 0; i < 400 && exp_b_q.size() != 0; i++) begin @(posedge clk); #1; end
      if (exp_b_q.size() != 0) begin
         check("done_timeout_b", 32'd0, 32'd1);
         exp_b_q.delete();
      end
   endtask

   // functional-port driver: random traffic or the directed values
   initial forever begin
      @(posedge clk); #3;
      if (rand_func) begin
         fa_addr = 8'($urandom);
         fa_we   = 1'($urandom_range(1));
         fa_din  = 4'($urandom);
      end else begin
         fa_addr = pt_addr;
         fa_we   = pt_we;
         fa_din  = pt_din;
      end
   end

   logic done_a_d = 1'b0, done_b_d = 1'b0;

   always @(negedge clk) begin : mon_a
      logic [17:0] o;
      logic [35:0] r;
      if (rst_a) begin
         done_a_d = 1'b0;
      end else begin
         if (busy_a) begin
            if (exp_op_q.size() == 0) begin
               check("op_overrun", 32'd1, 32'd0);
            end else begin
               o = exp_op_q.pop_front();
               check("op_we", 32'(ra_we), 32'(o[17:16] == 2'd2));
               if (o[17:16] != 2'd0) check("op_addr", 32'(ra_addr), 32'(o[15:8]));
               if (o[17:16] == 2'd2) check("op_data", 32'(ra_din), 32'(o[3:0]));
            end
         end else begin
            check("pass_a", 32'({ra_addr, ra_we, ra_din}), 32'({fa_addr, fa_we, fa_din}));
         end
         if (done_a && !done_a_d) begin
            if (exp_a_q.size() == 0) begin
               check("done_unexpected_a", 32'd1, 32'd0);
            end else begin
               r = exp_a_q.pop_front();
               check("cycles_a", 32'(cyc - start_cyc_a), 32'(r[35:20]));
               check("fail_a", 32'(fail_a), 32'(r[19]));
               check("fail_addr_a", 32'(faddr_a), 32'(r[18:11]));
               check("fail_elem_a", 32'(felem_a), 32'(r[10:8]));
               check("fail_count_a", 32'(fcnt_a), 32'(r[7:0]));
               check("ops_left_a", 32'(exp_op_q.size()), 32'd0);
            end
         end
         done_a_d = done_a;
      end
   end

   always @(negedge clk) begin : mon_b
      logic [35:0] r;
      if (rst_b) begin
         done_b_d = 1'b0;
      end else begin
         if (done_b && !done_b_d) begin
            if (exp_b_q.size() == 0) begin
               check("done_unexpected_b", 32'd1, 32'd0);
            end else begin
               r = exp_b_q.pop_front();
               check("cycles_b", 32'(cyc - start_cyc_b), 32'(r[35:20]));
               check("fail_b", 32'(fail_b), 32'(r[19]));
               check("fail_addr_b", 32'(faddr_b), 32'(r[18:11]));
               check("fail_elem_b", 32'(felem_b), 32'(r[10:8]));
               check("fail_count_b", 32'(fcnt_b), 32'(r[7:0]));
            end
         end
         done_b_d = done_b;
      end
   end

   initial begin
      for (int i = 0; i < WA; i++) mem_a[i] = '0;
      for (int i = 0; i < WB; i++) mem_b[i] = '0;
      set_faults(0, WA, LA);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy_a", 32'(busy_a), 32'd0);
      check("rst_done_a", 32'(done_a), 32'd0);
      check("rst_fail_a", 32'(fail_a), 32'd0);
      check("rst_faddr_a", 32'(faddr_a), 32'd0);
      check("rst_felem_a", 32'(felem_a), 32'd0);
      check("rst_fcnt_a", 32'(fcnt_a), 32'd0);
      check("rst_busy_b", 32'(busy_b), 32'd0);
      check("rst_done_b", 32'(done_b), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // functional write then read through the idle controller
      pt_addr = 8'h3A; pt_we = 1'b1; pt_din = 4'hC;
      @(posedge clk); #4;
      check("pt_addr", 32'(ra_addr), 32'h3A);
      check("pt_we", 32'(ra_we), 32'd1);
      check("pt_din", 32'(ra_din), 32'hC);
      pt_we = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pt_read", 32'(ra_dout), 32'hC);

      rand_func = 1'b1;
      run_a(0, 100, 0);
      run_a(1, 0, 0);
      check("sa1_fail", 32'(fail_a), 32'd1);
      check("sa1_faddr", 32'(faddr_a), 32'd5);
      check("sa1_felem", 32'(felem_a), 32'd1);
      check("sa1_fcnt", 32'(fcnt_a), 32'd3);
      rst_a = 1'b1;
      #1;
      check("rst_done_held", 32'(done_a), 32'd0);
      check("rst_fail_held", 32'(fail_a), 32'd0);
      check("rst_faddr_held", 32'(faddr_a), 32'd0);
      check("rst_felem_held", 32'(felem_a), 32'd0);
      check("rst_fcnt_held", 32'(fcnt_a), 32'd0);
      @(posedge clk); #1;
      rst_a = 1'b0;

      run_a(2, 0, 700);
      run_a(0, 0, 0);
      for (int n = 0; n < 3; n++) run_a(2, 0, 0);
      run_a(3, 0, 0);

      run_b(0);
      run_b(1);
      check("b_sa0_faddr", 32'(faddr_b), 32'd15);
      check("b_sa0_felem", 32'(felem_b), 32'd2);
      for (int n = 0; n < 2; n++) run_b(2);
      run_b(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
